// File: rtl/ctrl_seq_irq_if.sv
// Control bundle between the ctrl_seq_irq sequencer and the accumulator datapath.
// The master side is the sequencer: it samples the IRU opcode, the AC flags and
// the interrupt request, and drives every datapath strobe plus the status outputs.
interface ctrl_seq_irq_if #(
    parameter int OPC_W      = 8,
    parameter int OPND_BYTES = 1
);
    logic [OPC_W-1:0]      opcode;
    logic                  ZFLG;
    logic                  NFLG;
    logic                  IRQ;

    logic                  FETCH;
    logic                  INC_PC;
    logic                  LOAD_PC;
    logic                  LOAD_IRU;
    logic                  LOAD_AC;
    logic                  STORE_MEM;
    logic [OPND_BYTES-1:0] LOAD_OPND;
    logic                  LOAD_SP;
    logic                  SP_INC;
    logic                  SP_DEC;
    logic                  SP_ADDR;
    logic                  AC_SRC;
    logic [1:0]            PC_SRC;
    logic                  MEM_IN_SRC;
    logic                  IACK;
    logic                  IEN;
    logic                  HALTED;
    logic                  STK_FAULT;
    logic [4:0]            STATE;

    modport master (
        input  opcode, ZFLG, NFLG, IRQ,
        output FETCH, INC_PC, LOAD_PC, LOAD_IRU, LOAD_AC, STORE_MEM, LOAD_OPND,
               LOAD_SP, SP_INC, SP_DEC, SP_ADDR, AC_SRC, PC_SRC, MEM_IN_SRC,
               IACK, IEN, HALTED, STK_FAULT, STATE
    );

    modport slave (
        output opcode, ZFLG, NFLG, IRQ,
        input  FETCH, INC_PC, LOAD_PC, LOAD_IRU, LOAD_AC, STORE_MEM, LOAD_OPND,
               LOAD_SP, SP_INC, SP_DEC, SP_ADDR, AC_SRC, PC_SRC, MEM_IN_SRC,
               IACK, IEN, HALTED, STK_FAULT, STATE
    );
endinterface

// File: rtl/ctrl_seq_irq.sv
// Multi-cycle control sequencer for the accumulator CPU with a bounded-depth
// stack, maskable interrupt and HALT. The state register moves on the falling
// clock edge so that every strobe is stable around the datapath's rising edge.
// Jump conditions: 10 JMP always, 11 JZ (ZFLG), 12 JNZ (!ZFLG), 13 JN (NFLG),
// 14 JP (!NFLG). The JUMP state is always visited; LOAD_PC only when taken.
module ctrl_seq_irq #(
    parameter int OPC_W       = 8,
    parameter int OPND_BYTES  = 1,
    parameter int STACK_DEPTH = 16
) (
    input  logic           CLK,
    input  logic           RESET,
    ctrl_seq_irq_if.master bus
);

    typedef enum logic [4:0] {
        S_START    = 5'd0,
        S_PREP_U   = 5'd1,
        S_FETCH_U  = 5'd2,
        S_PREP_O   = 5'd3,
        S_FETCH_O  = 5'd4,
        S_MEM_WAIT = 5'd5,
        S_EXEC     = 5'd6,
        S_STORE    = 5'd7,
        S_JUMP     = 5'd8,
        S_LOADSP   = 5'd9,
        S_BOUND    = 5'd10,
        S_PUSH     = 5'd11,
        S_JSR      = 5'd12,
        S_STK_RD1  = 5'd13,
        S_STK_RD2  = 5'd14,
        S_INT      = 5'd15,
        S_HALT     = 5'd16
    } state_e;

    localparam logic [7:0]       DEPTH_MAX = 8'(STACK_DEPTH);
    localparam logic [1:0]       OPND_LAST = 2'(OPND_BYTES - 1);

    localparam logic [OPC_W-1:0] OP_NOP  = OPC_W'(8'h00);
    localparam logic [OPC_W-1:0] OP_CLR  = OPC_W'(8'h04);
    localparam logic [OPC_W-1:0] OP_JMP  = OPC_W'(8'h10);
    localparam logic [OPC_W-1:0] OP_JZ   = OPC_W'(8'h11);
    localparam logic [OPC_W-1:0] OP_JNZ  = OPC_W'(8'h12);
    localparam logic [OPC_W-1:0] OP_JN   = OPC_W'(8'h13);
    localparam logic [OPC_W-1:0] OP_JP   = OPC_W'(8'h14);
    localparam logic [OPC_W-1:0] OP_PUSH = OPC_W'(8'h16);
    localparam logic [OPC_W-1:0] OP_POP  = OPC_W'(8'h17);
    localparam logic [OPC_W-1:0] OP_JSR  = OPC_W'(8'h18);
    localparam logic [OPC_W-1:0] OP_RTS  = OPC_W'(8'h19);
    localparam logic [OPC_W-1:0] OP_RTI  = OPC_W'(8'h1A);
    localparam logic [OPC_W-1:0] OP_EI   = OPC_W'(8'h1B);
    localparam logic [OPC_W-1:0] OP_DI   = OPC_W'(8'h1C);
    localparam logic [OPC_W-1:0] OP_HALT = OPC_W'(8'h1D);

    state_e     state_q, state_d;
    logic [7:0] depth_q, depth_d;
    logic [1:0] opnd_q,  opnd_d;
    logic       ien_q,   ien_d;
    logic       fault_q, fault_d;
    logic       final_st;

    // Execute class of an opcode that carries operand bytes (JSR handled by caller).
    function automatic state_e opnd_class(input logic [OPC_W-1:0] op);
        state_e s;
        s = S_BOUND;
        case (op)
            OPC_W'(8'h02), OPC_W'(8'h06), OPC_W'(8'h08),
            OPC_W'(8'h0E), OPC_W'(8'h0F):                 s = S_EXEC;
            OPC_W'(8'h01), OPC_W'(8'h05), OPC_W'(8'h07),
            OPC_W'(8'h09), OPC_W'(8'h0A), OPC_W'(8'h0B),
            OPC_W'(8'h0C), OPC_W'(8'h0D):                 s = S_MEM_WAIT;
            OPC_W'(8'h03):                                s = S_STORE;
            OP_JMP, OP_JZ, OP_JNZ, OP_JN, OP_JP:          s = S_JUMP;
            OPC_W'(8'h15):                                s = S_LOADSP;
            default:                                      s = S_BOUND;
        endcase
        return s;
    endfunction

    // Branch condition for the jump class.
    function automatic logic jump_taken(input logic [OPC_W-1:0] op,
                                        input logic z, input logic n);
        logic t;
        t = 1'b0;
        case (op)
            OP_JMP:  t = 1'b1;
            OP_JZ:   t = z;
            OP_JNZ:  t = ~z;
            OP_JN:   t = n;
            OP_JP:   t = ~n;
            default: t = 1'b0;
        endcase
        return t;
    endfunction

    // Sequencer registers: state, live stack depth, operand index, IEN and sticky fault.
    always_ff @(negedge CLK or posedge RESET) begin
        if (RESET) begin
            state_q <= S_START;
            depth_q <= '0;
            opnd_q  <= '0;
            ien_q   <= 1'b0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            depth_q <= depth_d;
            opnd_q  <= opnd_d;
            ien_q   <= ien_d;
            fault_q <= fault_d;
        end
    end

    // Next-state decode and per-state strobes; the boundary check runs last.
    always_comb begin
        state_d  = state_q;
        depth_d  = depth_q;
        opnd_d   = opnd_q;
        ien_d    = ien_q;
        fault_d  = fault_q;
        final_st = 1'b0;

        bus.FETCH      = 1'b0;
        bus.INC_PC     = 1'b0;
        bus.LOAD_PC    = 1'b0;
        bus.LOAD_IRU   = 1'b0;
        bus.LOAD_AC    = 1'b0;
        bus.STORE_MEM  = 1'b0;
        bus.LOAD_OPND  = '0;
        bus.LOAD_SP    = 1'b0;
        bus.SP_INC     = 1'b0;
        bus.SP_DEC     = 1'b0;
        bus.SP_ADDR    = 1'b0;
        bus.AC_SRC     = 1'b0;
        bus.PC_SRC     = 2'd0;
        bus.MEM_IN_SRC = 1'b0;
        bus.IACK       = 1'b0;

        case (state_q)
            S_START: state_d = S_PREP_U;

            S_PREP_U: begin
                bus.FETCH = 1'b1;
                state_d   = S_FETCH_U;
            end

            // IRU is written on this cycle's rising edge, so opcode is valid by
            // the falling edge that leaves the state.
            S_FETCH_U: begin
                bus.FETCH    = 1'b1;
                bus.INC_PC   = 1'b1;
                bus.LOAD_IRU = 1'b1;
                opnd_d       = '0;
                case (bus.opcode)
                    OP_NOP: state_d = S_BOUND;
                    OP_CLR: state_d = S_EXEC;
                    OP_PUSH: begin
                        if (depth_q < DEPTH_MAX) begin
                            state_d = S_PUSH;
                        end else begin
                            fault_d = 1'b1;
                            state_d = S_HALT;
                        end
                    end
                    OP_POP, OP_RTS, OP_RTI: begin
                        if (depth_q == 8'd0) begin
                            fault_d = 1'b1;
                            state_d = S_HALT;
                        end else begin
                            state_d = S_STK_RD1;
                        end
                    end
                    // EI/DI end here without a boundary, so the new IEN is
                    // first seen at the following instruction's boundary.
                    OP_EI: begin
                        ien_d   = 1'b1;
                        state_d = S_PREP_U;
                    end
                    OP_DI: begin
                        ien_d   = 1'b0;
                        state_d = S_PREP_U;
                    end
                    OP_HALT: state_d = S_HALT;
                    default: state_d = S_PREP_O;
                endcase
            end

            S_PREP_O: begin
                bus.FETCH = 1'b1;
                state_d   = S_FETCH_O;
            end

            S_FETCH_O: begin
                bus.FETCH     = 1'b1;
                bus.INC_PC    = 1'b1;
                bus.LOAD_OPND = OPND_BYTES'(1) << opnd_q;
                if (opnd_q == OPND_LAST) begin
                    opnd_d = '0;
                    if (bus.opcode == OP_JSR) begin
                        if (depth_q < DEPTH_MAX) begin
                            state_d = S_JSR;
                        end else begin
                            fault_d = 1'b1;
                            state_d = S_HALT;
                        end
                    end else begin
                        state_d = opnd_class(bus.opcode);
                    end
                end else begin
                    opnd_d  = opnd_q + 2'd1;
                    state_d = S_PREP_O;
                end
            end

            S_MEM_WAIT: state_d = S_EXEC;

            S_EXEC: begin
                bus.LOAD_AC = 1'b1;
                final_st    = 1'b1;
            end

            S_STORE: begin
                bus.STORE_MEM = 1'b1;
                final_st      = 1'b1;
            end

            S_JUMP: begin
                bus.LOAD_PC = jump_taken(bus.opcode, bus.ZFLG, bus.NFLG);
                final_st    = 1'b1;
            end

            S_LOADSP: begin
                bus.LOAD_SP = 1'b1;
                depth_d     = 8'd0;
                final_st    = 1'b1;
            end

            S_BOUND: final_st = 1'b1;

            S_PUSH: begin
                bus.SP_DEC    = 1'b1;
                bus.SP_ADDR   = 1'b1;
                bus.STORE_MEM = 1'b1;
                depth_d       = depth_q + 8'd1;
                final_st      = 1'b1;
            end

            // Return address (PC) goes onto the stack while PC loads the operand.
            S_JSR: begin
                bus.SP_DEC     = 1'b1;
                bus.SP_ADDR    = 1'b1;
                bus.STORE_MEM  = 1'b1;
                bus.MEM_IN_SRC = 1'b1;
                bus.LOAD_PC    = 1'b1;
                depth_d        = depth_q + 8'd1;
                final_st       = 1'b1;
            end

            // First read cycle only addresses RAM; data is captured next cycle.
            S_STK_RD1: begin
                bus.SP_ADDR = 1'b1;
                state_d     = S_STK_RD2;
            end

            S_STK_RD2: begin
                bus.SP_ADDR = 1'b1;
                bus.SP_INC  = 1'b1;
                depth_d     = depth_q - 8'd1;
                if (bus.opcode == OP_POP) begin
                    bus.LOAD_AC = 1'b1;
                    bus.AC_SRC  = 1'b1;
                end else begin
                    bus.LOAD_PC = 1'b1;
                    bus.PC_SRC  = 2'd1;
                end
                if (bus.opcode == OP_RTI) begin
                    ien_d = 1'b1;
                end
                final_st = 1'b1;
            end

            S_INT: begin
                bus.SP_DEC     = 1'b1;
                bus.SP_ADDR    = 1'b1;
                bus.STORE_MEM  = 1'b1;
                bus.MEM_IN_SRC = 1'b1;
                bus.LOAD_PC    = 1'b1;
                bus.PC_SRC     = 2'd2;
                bus.IACK       = 1'b1;
                ien_d          = 1'b0;
                depth_d        = depth_q + 8'd1;
                state_d        = S_PREP_U;
            end

            S_HALT: state_d = S_HALT;

            default: state_d = S_START;
        endcase

        // Instruction boundary: the interrupt needs a free stack slot for the PC,
        // judged against the depth this instruction leaves behind.
        if (final_st) begin
            state_d = S_PREP_U;
            if (bus.IRQ && ien_q) begin
                if (depth_d < DEPTH_MAX) begin
                    state_d = S_INT;
                end else begin
                    fault_d = 1'b1;
                    state_d = S_HALT;
                end
            end
        end
    end

    assign bus.IEN       = ien_q;
    assign bus.STK_FAULT = fault_q;
    assign bus.HALTED    = (state_q == S_HALT);
    assign bus.STATE     = state_q;

endmodule

// File: tb/tb_ctrl_seq_irq.sv
// Directed bench for ctrl_seq_irq with OPND_BYTES=2 and STACK_DEPTH=2.
// The sequencer moves on the falling edge; the bench samples 2 time units after it.
module tb_ctrl_seq_irq;
    localparam int OPC_W       = 8;
    localparam int OPND_BYTES  = 2;
    localparam int STACK_DEPTH = 2;

    localparam logic [4:0] ST_START   = 5'd0;
    localparam logic [4:0] ST_PREP_U  = 5'd1;
    localparam logic [4:0] ST_FETCH_U = 5'd2;
    localparam logic [4:0] ST_PREP_O  = 5'd3;
    localparam logic [4:0] ST_FETCH_O = 5'd4;
    localparam logic [4:0] ST_EXEC    = 5'd6;
    localparam logic [4:0] ST_JUMP    = 5'd8;
    localparam logic [4:0] ST_LOADSP  = 5'd9;
    localparam logic [4:0] ST_BOUND   = 5'd10;
    localparam logic [4:0] ST_PUSH    = 5'd11;
    localparam logic [4:0] ST_STK_RD1 = 5'd13;
    localparam logic [4:0] ST_STK_RD2 = 5'd14;
    localparam logic [4:0] ST_INT     = 5'd15;
    localparam logic [4:0] ST_HALT    = 5'd16;

    logic        CLK = 1'b0;
    logic        RESET;
    int          checks   = 0;
    int          failures = 0;
    logic        iack_seen;
    logic [16:0] strb;

    ctrl_seq_irq_if #(.OPC_W(OPC_W), .OPND_BYTES(OPND_BYTES)) bus ();

    ctrl_seq_irq #(
        .OPC_W(OPC_W), .OPND_BYTES(OPND_BYTES), .STACK_DEPTH(STACK_DEPTH)
    ) dut (
        .CLK(CLK), .RESET(RESET), .bus(bus)
    );

    always #5 CLK = ~CLK;

    assign strb = {bus.FETCH, bus.INC_PC, bus.LOAD_PC, bus.LOAD_IRU, bus.LOAD_AC,
                   bus.STORE_MEM, bus.LOAD_OPND, bus.LOAD_SP, bus.SP_INC, bus.SP_DEC,
                   bus.SP_ADDR, bus.AC_SRC, bus.PC_SRC, bus.MEM_IN_SRC, bus.IACK};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge CLK);
            #2;
            iack_seen = iack_seen | bus.IACK;
        end
    endtask

    task automatic do_reset();
        RESET = 1'b1;
        bus.IRQ = 1'b0;
        #1;
        chk("reset_clears_fault", {31'd0, bus.STK_FAULT}, 32'd0);
        run(1);
        RESET = 1'b0;
        run(1);
        chk("reset_to_prep_u", {27'd0, bus.STATE}, {27'd0, ST_PREP_U});
    endtask

    initial begin
        RESET      = 1'b1;
        bus.opcode = 8'h10;
        bus.ZFLG   = 1'b0;
        bus.NFLG   = 1'b0;
        bus.IRQ    = 1'b0;
        iack_seen  = 1'b0;
        #12;
        chk("rst_state",   {27'd0, bus.STATE}, {27'd0, ST_START});
        chk("rst_strobes", {15'd0, strb}, 32'd0);
        chk("rst_flags",   {29'd0, bus.IEN, bus.HALTED, bus.STK_FAULT}, 32'd0);
        RESET = 1'b0;
        run(1);
        chk("prep_u_first", {27'd0, bus.STATE}, {27'd0, ST_PREP_U});
        chk("prep_u_fetch", {31'd0, bus.FETCH}, 32'd1);

        // JMP with two operand bytes: 7 states PREP_U..JUMP
        run(1);
        chk("fetch_u_strobes", {29'd0, bus.FETCH, bus.INC_PC, bus.LOAD_IRU}, 32'd7);
        run(1);
        chk("jmp_prep_o", {27'd0, bus.STATE}, {27'd0, ST_PREP_O});
        run(1);
        chk("jmp_opnd0", {30'd0, bus.LOAD_OPND}, 32'd1);
        run(2);
        chk("jmp_opnd1", {30'd0, bus.LOAD_OPND}, 32'd2);
        run(1);
        chk("jmp_state", {27'd0, bus.STATE}, {27'd0, ST_JUMP});
        chk("jmp_load_pc", {29'd0, bus.LOAD_PC, bus.PC_SRC}, 32'd4);
        run(1);
        chk("jmp_back_prep_u", {27'd0, bus.STATE}, {27'd0, ST_PREP_U});

        // Reset asserted in the middle of FETCH_O
        run(3);
        chk("mid_fetch_o", {27'd0, bus.STATE}, {27'd0, ST_FETCH_O});
        RESET = 1'b1;
        #1;
        chk("async_rst_state",   {27'd0, bus.STATE}, {27'd0, ST_START});
        chk("async_rst_strobes", {15'd0, strb}, 32'd0);
        run(1);
        chk("rst_held_start", {27'd0, bus.STATE}, {27'd0, ST_START});
        RESET = 1'b0;
        run(1);
        chk("rst_release_prep_u", {27'd0, bus.STATE}, {27'd0, ST_PREP_U});

        // LOADSP, PUSH, PUSH, PUSH with a depth of 2
        bus.opcode = 8'h15;
        run(6);
        chk("loadsp", {27'd0, bus.STATE, bus.LOAD_SP} >> 0, {26'd0, ST_LOADSP, 1'b1});
        run(1);
        bus.opcode = 8'h16;
        run(2);
        chk("push1", {28'd0, bus.STORE_MEM, bus.SP_DEC, bus.SP_ADDR, bus.MEM_IN_SRC}, 32'he);
        run(1);
        chk("push1_single", {26'd0, bus.STATE, bus.STORE_MEM}, {26'd0, ST_PREP_U, 1'b0});
        run(2);
        chk("push2", {28'd0, bus.STORE_MEM, bus.SP_DEC, bus.SP_ADDR, bus.MEM_IN_SRC}, 32'he);
        run(3);
        chk("push3_halt", {27'd0, bus.STATE}, {27'd0, ST_HALT});
        chk("push3_flags", {28'd0, bus.STK_FAULT, bus.HALTED, bus.STORE_MEM, bus.SP_DEC}, 32'hc);
        bus.IRQ   = 1'b1;
        iack_seen = 1'b0;
        run(3);
        chk("halt_absorbs", {26'd0, bus.STATE, iack_seen}, {26'd0, ST_HALT, 1'b0});
        do_reset();

        // LOADSP then POP underflows
        bus.opcode = 8'h15;
        run(7);
        bus.opcode = 8'h17;
        run(2);
        chk("pop_uflow_halt", {27'd0, bus.STATE}, {27'd0, ST_HALT});
        chk("pop_uflow_flags", {29'd0, bus.STK_FAULT, bus.SP_INC, bus.LOAD_AC}, 32'h4);
        do_reset();

        // LOADSP, PUSH, POP
        bus.opcode = 8'h15;
        run(7);
        bus.opcode = 8'h16;
        run(3);
        bus.opcode = 8'h17;
        run(2);
        chk("pop_rd1", {24'd0, bus.STATE, bus.SP_ADDR, bus.SP_INC, bus.LOAD_AC},
            {24'd0, ST_STK_RD1, 3'b100});
        run(1);
        chk("pop_rd2", {22'd0, bus.STATE, bus.SP_ADDR, bus.SP_INC, bus.LOAD_AC, bus.AC_SRC, bus.LOAD_PC},
            {22'd0, ST_STK_RD2, 5'b11110});
        run(1);
        chk("pop_done", {27'd0, bus.STATE}, {27'd0, ST_PREP_U});
        run(2);
        chk("pop_depth_zero", {26'd0, bus.STATE, bus.STK_FAULT}, {26'd0, ST_HALT, 1'b1});
        do_reset();

        // EI, NOP with IRQ pending, handler, RTI
        bus.IRQ    = 1'b1;
        bus.opcode = 8'h1B;
        iack_seen  = 1'b0;
        run(1);
        chk("ei_fetch_ien_low", {31'd0, bus.IEN}, 32'd0);
        run(1);
        chk("ei_done", {25'd0, bus.STATE, bus.IEN, iack_seen}, {25'd0, ST_PREP_U, 2'b10});
        bus.opcode = 8'h00;
        run(2);
        chk("nop_bound", {27'd0, bus.STATE}, {27'd0, ST_BOUND});
        run(1);
        chk("int_state", {27'd0, bus.STATE}, {27'd0, ST_INT});
        chk("int_strobes", {26'd0, bus.IACK, bus.STORE_MEM, bus.SP_DEC, bus.SP_ADDR, bus.LOAD_PC, bus.MEM_IN_SRC},
            32'h3f);
        chk("int_pc_src", {30'd0, bus.PC_SRC}, 32'd2);
        run(1);
        chk("int_after", {25'd0, bus.STATE, bus.IACK, bus.IEN}, {25'd0, ST_PREP_U, 2'b00});
        iack_seen = 1'b0;
        run(3);
        chk("handler_no_reint", {26'd0, bus.STATE, iack_seen}, {26'd0, ST_PREP_U, 1'b0});
        bus.IRQ    = 1'b0;
        bus.opcode = 8'h1A;
        run(3);
        chk("rti_rd2", {29'd0, bus.LOAD_PC, bus.SP_INC, bus.LOAD_AC}, 32'h6);
        chk("rti_pc_src", {30'd0, bus.PC_SRC}, 32'd1);
        run(1);
        chk("rti_ien", {26'd0, bus.STATE, bus.IEN}, {26'd0, ST_PREP_U, 1'b1});

        // Stack full at a boundary with an enabled interrupt -> fault
        bus.opcode = 8'h16;
        run(6);
        chk("two_pushes", {26'd0, bus.STATE, bus.STK_FAULT}, {26'd0, ST_PREP_U, 1'b0});
        bus.IRQ    = 1'b1;
        bus.opcode = 8'h00;
        iack_seen  = 1'b0;
        run(3);
        chk("int_full_fault", {25'd0, bus.STATE, bus.STK_FAULT, iack_seen}, {25'd0, ST_HALT, 2'b10});
        do_reset();

        // DI with IRQ held across ALU, jump and memory instructions
        bus.opcode = 8'h1B;
        run(2);
        bus.IRQ    = 1'b1;
        bus.opcode = 8'h1C;
        iack_seen  = 1'b0;
        run(2);
        chk("di_ien", {26'd0, bus.STATE, bus.IEN}, {26'd0, ST_PREP_U, 1'b0});
        bus.opcode = 8'h02;
        run(6);
        chk("alu_exec", {25'd0, bus.STATE, bus.LOAD_AC, bus.AC_SRC}, {25'd0, ST_EXEC, 2'b10});
        run(1);
        bus.opcode = 8'h11;
        bus.ZFLG   = 1'b0;
        run(6);
        chk("jz_not_taken", {26'd0, bus.STATE, bus.LOAD_PC}, {26'd0, ST_JUMP, 1'b0});
        run(1);
        bus.opcode = 8'h10;
        run(7);
        bus.opcode = 8'h01;
        run(8);
        chk("di_no_iack", {26'd0, bus.STATE, iack_seen}, {26'd0, ST_PREP_U, 1'b0});

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Global guard so the run always ends on its own
    initial begin
        #100000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end
endmodule

// File: doc/ctrl_seq_irq.md
Name: ctrl_seq_irq

Overview:
- Parametrised next-generation multi-cycle control sequencer for the accumulator CPU.
- Fetches an opcode plus 0..OPND_BYTES operand bytes, then sequences ALU, memory, jump and stack classes.
- Adds a bounded-depth stack with sticky overflow/underflow fault, a maskable interrupt with IRQ/IACK handshake, RTI/EI/DI/HALT, and a 2-bit PC source select.
- Drives the existing datapath (PC, IR, AC, SP, RAM) through level control strobes.

Parameters:
- OPC_W, 8, opcode width.
- OPND_BYTES, 1, operand bytes fetched for two-byte-class instructions; legal values 1..2.
- STACK_DEPTH, 16, maximum live stack entries; legal 1..255.

Ports:
- CLK  in  1  clock; the state register advances on the falling edge, the datapath captures on the rising edge.
- RESET  in  1  asynchronous, active-high reset.
- opcode  in  OPC_W  IRU contents.
- ZFLG, NFLG  in  1  AC zero / negative flags.
- IRQ  in  1  level interrupt request; held by the source until IACK.
- FETCH, INC_PC, LOAD_PC, LOAD_IRU, LOAD_AC, STORE_MEM  out  1  datapath strobes, same meaning as the previous generation.
- LOAD_OPND  out  OPND_BYTES  one-hot load enable for operand byte k (k=0 is the low byte).
- LOAD_SP, SP_INC, SP_DEC, SP_ADDR  out  1  stack pointer control and address-mux select.
- AC_SRC  out  1  0 = ALU result, 1 = RAM_out.
- PC_SRC  out  2  0 = operand, 1 = RAM_out, 2 = interrupt vector, 3 = reserved.
- MEM_IN_SRC  out  1  0 = AC, 1 = PC.
- IACK  out  1  one-cycle interrupt acknowledge.
- IEN  out  1  interrupt enable flag.
- HALTED  out  1  high in the HALT state.
- STK_FAULT  out  1  sticky stack fault.
- STATE  out  5  current state encoding.

Behaviour:
- Reset: state=START. All strobes, PC_SRC, IACK, IEN, HALTED and STK_FAULT are 0. Depth counter=0. RESET mid-instruction aborts immediately with no further strobes.
- Outputs are combinational from state and inputs. Every strobe defaults to 0 in every state.
- Fetch sequence: START -> PREP_U (FETCH) -> FETCH_U (FETCH, INC_PC, LOAD_IRU).
- Single-byte opcodes skip the operand fetch: 00 NOP, 04 CLR, 16 PUSH, 17 POP, 19 RTS, 1A RTI, 1B EI, 1C DI, 1D HALT.
- All other opcodes loop PREP_O (FETCH) -> FETCH_O (FETCH, INC_PC, LOAD_OPND[k]) for k=0..OPND_BYTES-1, then decode.
- Instruction classes:
  - 02/06/08/0E/0F -> EXEC (LOAD_AC).
  - 01/05/07/09-0D -> MEM_WAIT -> EXEC.
  - 03 -> STORE (STORE_MEM).
  - 10-14 -> JUMP, with the same conditions as the previous generation and PC_SRC=0.
  - 15 LOADSP -> LOAD_SP, depth:=0.
  - 00 NOP -> no strobes, straight to BOUNDARY; 04 CLR -> EXEC (LOAD_AC).
  - Any undefined opcode behaves as NOP after its fetch.
- EI and DI set and clear IEN in their FETCH_U cycle (registered on the falling edge). They take effect from the next boundary.
- PUSH:
  - depth<STACK_DEPTH: SP_DEC, SP_ADDR, STORE_MEM, MEM_IN_SRC=0; depth+1.
  - Otherwise: STK_FAULT:=1, no strobes, go to HALT.
- JSR (18):
  - Same overflow check as PUSH.
  - Success: SP_DEC, SP_ADDR, STORE_MEM, MEM_IN_SRC=1, LOAD_PC, PC_SRC=0; depth+1.
- POP, RTS and RTI:
  - depth==0: STK_FAULT:=1, go to HALT.
  - Otherwise, cycle 1 STK_RD1 asserts SP_ADDR.
  - Cycle 2 STK_RD2 asserts SP_ADDR and SP_INC; depth-1.
    - POP also asserts LOAD_AC with AC_SRC=1.
    - RTS and RTI also assert LOAD_PC with PC_SRC=1.
    - RTI additionally sets IEN:=1.
- Boundary check: every execute-final state (and NOP) evaluates before returning to PREP_U.
  - If IRQ & IEN & depth<STACK_DEPTH, go to INT instead of PREP_U.
  - If IRQ & IEN & depth==STACK_DEPTH, set STK_FAULT and go to HALT.
- INT (one cycle):
  - SP_DEC, SP_ADDR, STORE_MEM, MEM_IN_SRC=1, LOAD_PC, PC_SRC=2, IACK=1.
  - IEN:=0, depth+1, then go to PREP_U.
- HALT: absorbing state; HALTED=1, all strobes 0. Only RESET exits; IRQ is ignored.
- STK_FAULT clears only on RESET.

Test Plan:
- Reset: RESET pulse mid-FETCH_O with OPND_BYTES=2 -> all outputs 0 and STATE=START the same cycle; PREP_U follows the first falling edge after release.
- OPND_BYTES=2, opcode 10 (JMP) -> LOAD_OPND=01 then 10 on successive fetch cycles, then a JUMP cycle with LOAD_PC=1 and PC_SRC=0; 7 states in total.
- STACK_DEPTH=2: LOADSP, PUSH, PUSH, PUSH -> first two pushes each give exactly one STORE_MEM+SP_DEC; the third gives STK_FAULT=1, HALTED=1 and no STORE_MEM.
- LOADSP then POP -> STK_FAULT=1 with no SP_INC or LOAD_AC; LOADSP, PUSH, POP -> STK_RD2 asserts LOAD_AC, AC_SRC=1 and SP_INC, and depth returns to 0.
- EI, NOP with IRQ=1 -> INT after the NOP with IACK for one cycle, PC_SRC=2, MEM_IN_SRC=1 and IEN falls. IRQ held through the handler raises no second IACK. RTI -> PC_SRC=1 and IEN=1.
- DI with IRQ=1 held for 20 cycles across ALU and jump instructions -> IACK never asserts.
